pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-004 SHALL have port imem_addr  output  10  byte address of the request, word aligned.
REQ-005 SHALL have port imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-006 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-007 SHALL have port instr_valid  output  1  instr_out/instr_pc are valid for decode.
REQ-008 SHALL have port instr_ready  input  1  decode accepts the instruction this cycle.
REQ-009 SHALL have port instr_out  output  32  held instruction word.
REQ-010 SHALL have port instr_pc  output  10  address of instr_out.
REQ-011 SHALL have port redirect  input  1  taken branch, jal or jalr resolved this cycle.
REQ-012 SHALL have port redirect_pc  input  10  new fetch address.
REQ-013 SHALL have port halt  input  1  stop fetching.
REQ-014 SHALL have port halted  output  1  FSM is in HALT.
REQ-015 SHALL have port misalign_err  output  1  sticky flag: redirect_pc[1:0] was nonzero.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, HOLD and HALT.
REQ-017 SHALL move IDLE->REQ unconditionally on the first cycle after reset.
REQ-018 SHALL, in REQ, drive imem_req=1 with imem_addr=pc, and stay in REQ while imem_ready=0.
REQ-019 SHALL, in REQ with imem_ready=1, latch instr_out=imem_rdata and instr_pc=pc, set pc<=pc+4 (mod 1024), and go to HOLD.
REQ-020 SHALL, in HOLD, drive instr_valid=1, hold instr_out/instr_pc stable, and go to REQ when instr_ready=1.
REQ-021 SHALL drive imem_req=0 and instr_valid=0 in IDLE and HALT.
REQ-022 SHALL, on redirect in REQ or HOLD, set pc<=redirect_pc with bits [1:0] forced to 0, discard any held or returning word, drop instr_valid and enter REQ next cycle.
REQ-023 SHALL let redirect win over imem_ready and instr_ready in the same cycle; the discarded word is never presented.
REQ-024 SHALL set misalign_err when redirect is applied with redirect_pc[1:0]!=0; it clears only on reset.
REQ-025 SHALL enter HALT from any state on halt=1, leave HALT only by reset, and let halt win over redirect in the same cycle.
REQ-026 SHALL wrap pc+4 from 1020 to 0 without any flag.

Reset
REQ-027 SHALL, on reset, set state=IDLE, pc=0, instr_out=0, instr_pc=0, misalign_err=0, and drive all outputs 0.
REQ-028 SHALL let reset mid-fetch abandon the in-flight request; an imem_ready in the reset cycle is ignored.

Configuration
REQ-029 SHALL, with PC_SEQ_PREFETCH_EN defined, add a one-entry prefetch buffer: in HOLD, imem_req=1 for pc; a returned word is buffered, then presented in the cycle after instr_ready, with no REQ cycle.
REQ-030 SHALL, with PC_SEQ_PREFETCH_EN defined, flush the prefetch buffer on redirect, halt and reset.
REQ-031 SHALL, without PC_SEQ_PREFETCH_EN, allow at most one outstanding request, so peak throughput is one instruction per 2 cycles.

Structure
REQ-032 SHALL take the state encodings, PC width (10), instruction width (32) and PC step (4) from the shared package.
REQ-033 SHALL place the optional prefetch buffer in sub-module pc_prefetch_buf; the FSM stays in pc_sequencer.

Verification
REQ-034 SHALL cover: reset for 2 cycles, then imem_ready=1 always and instr_ready=1 always -> imem_addr sequence 0,4,8, and instr_valid every other cycle without the macro.
REQ-035 SHALL cover: imem_ready held 0 for 3 cycles -> imem_req stays 1 with imem_addr constant, and instr_valid=0.
REQ-036 SHALL cover: in HOLD with instr_pc=8, redirect=1 with redirect_pc=24 -> instr_valid drops, and the next imem_addr is 24.
REQ-037 SHALL cover: redirect_pc=26 -> imem_addr=24, and misalign_err=1 until reset.
REQ-038 SHALL cover: halt and redirect in the same cycle -> halted=1, imem_req=0, and redirect ignored.
REQ-039 SHALL cover: pc=1020 fetched and accepted -> next imem_addr=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// pc_sequencer_pkg : shared widths, PC step and FSM encodings for the sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam pc_t PC_STEP = 10'd4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;
    localparam state_t ST_HALT = 2'd3;

    function automatic pc_t align_pc(input pc_t addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// ============================================================================
// pc_sequencer_if : fetch-side memory, decode handshake and control signals
// Revision 1.0
// ============================================================================
`default_nettype none

interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic   imem_req;
    pc_t    imem_addr;
    logic   imem_ready;
    instr_t imem_rdata;
    logic   instr_valid;
    logic   instr_ready;
    instr_t instr_out;
    pc_t    instr_pc;
    logic   redirect;
    pc_t    redirect_pc;
    logic   halt;
    logic   halted;
    logic   misalign_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc, halted, misalign_err,
        input  imem_ready, imem_rdata, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, halted, misalign_err,
        output imem_ready, imem_rdata, instr_ready, redirect, redirect_pc, halt
    );

endinterface

`default_nettype wire

// File: rtl/pc_prefetch_buf.sv
// ============================================================================
// pc_prefetch_buf : one-entry holding slot for a word fetched ahead of decode
// Revision 1.0
// ============================================================================
`default_nettype none

module pc_prefetch_buf
    import pc_sequencer_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   reset,
    input  wire logic   flush,
    input  wire logic   load,
    input  wire logic   consume,
    input  wire instr_t load_data,
    input  wire pc_t    load_pc,
    output logic        valid,
    output instr_t      data,
    output pc_t         pc
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : instruction fetch sequencer (IDLE/REQ/HOLD/HALT) with redirect
// Optional one-entry prefetch enabled by defining PC_SEQ_PREFETCH_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    pc_sequencer_if.master  bus
);

`ifdef PC_SEQ_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    state_t r_state;
    state_t w_next_state;
    pc_t    r_pc;
    instr_t r_instr;
    pc_t    r_instr_pc;
    logic   r_misalign;

    logic   w_req;
    logic   w_active;
    logic   w_redirect_take;
    logic   w_fetch_hit;
    logic   w_load_instr;
    logic   w_take_buf;
    logic   w_buf_load;
    logic   w_flush;
    logic   w_buf_valid;
    instr_t w_buf_data;
    pc_t    w_buf_pc;

    // Halt outranks redirect, and redirect outranks any returning or held word.
    assign w_active        = (r_state == ST_REQ) || (r_state == ST_HOLD);
    assign w_redirect_take = bus.redirect && w_active && !bus.halt;
    assign w_fetch_hit     = w_req && bus.imem_ready && !bus.redirect && !bus.halt;
    assign w_load_instr    = w_fetch_hit && ((r_state == ST_REQ) || bus.instr_ready);
    assign w_buf_load      = w_fetch_hit && (r_state == ST_HOLD) && !bus.instr_ready;
    assign w_take_buf      = (r_state == ST_HOLD) && bus.instr_ready && w_buf_valid
                             && !bus.redirect && !bus.halt;
    assign w_flush         = bus.halt || w_redirect_take;

    pc_prefetch_buf u_prefetch_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_flush),
        .load      (w_buf_load),
        .consume   (w_take_buf),
        .load_data (bus.imem_rdata),
        .load_pc   (r_pc),
        .valid     (w_buf_valid),
        .data      (w_buf_data),
        .pc        (w_buf_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.halt) begin
            w_next_state = ST_HALT;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_REQ;
                ST_REQ: begin
                    if (bus.redirect)        w_next_state = ST_REQ;
                    else if (bus.imem_ready) w_next_state = ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.redirect)         w_next_state = ST_REQ;
                    else if (bus.instr_ready) w_next_state = (w_buf_valid || w_fetch_hit)
                                                             ? ST_HOLD : ST_REQ;
                end
                default: w_next_state = ST_HALT;
            endcase
        end
    end

    always_comb begin
        w_req            = (r_state == ST_REQ)
                           || (PREFETCH && (r_state == ST_HOLD) && !w_buf_valid);
        bus.imem_req     = w_req;
        bus.imem_addr    = w_req ? r_pc : '0;
        bus.instr_valid  = (r_state == ST_HOLD) && !bus.redirect && !bus.halt;
        bus.instr_out    = r_instr;
        bus.instr_pc     = r_instr_pc;
        bus.halted       = (r_state == ST_HALT);
        bus.misalign_err = r_misalign;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_misalign <= 1'b0;
        end else begin
            if (w_redirect_take) begin
                r_pc <= align_pc(bus.redirect_pc);
                if (bus.redirect_pc[1:0] != 2'b00) r_misalign <= 1'b1;
            end else if (w_fetch_hit) begin
                r_pc <= r_pc + PC_STEP;
            end

            if (w_load_instr) begin
                r_instr    <= bus.imem_rdata;
                r_instr_pc <= r_pc;
            end else if (w_take_buf) begin
                r_instr    <= w_buf_data;
                r_instr_pc <= w_buf_pc;
            end
        end
    end

endmodule

`default_nettype wire
